// File: rtl/wb_burst_pkg.sv
// Shared state encoding and Wishbone cycle-type codes for the burst master.
package wb_burst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_BEAT,
        RD_BEAT,
        DONE,
        ABORT
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_burst_master.sv
// Command/data streams to Wishbone B3 incrementing bursts; cyc rises the cycle after accept.
// Write beats stall on wdat_valid, read data returns one cycle after ack, no ack for TIMEOUT cycles aborts.
module wb_burst_master
    import wb_burst_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LENW    = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic            wb_clk_i,
    input  logic            wb_resetn,
    input  logic            sdr_init_done,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [LENW-1:0] cmd_len,
    input  logic [3:0]      cmd_sel,
    input  logic            wdat_valid,
    output logic            wdat_ready,
    input  logic [DW-1:0]   wdat,
    output logic            rdat_valid,
    output logic [DW-1:0]   rdat,
    output logic            cmd_done,
    output logic            cmd_err,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_addr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [3:0]      wb_sel_o,
    output logic [2:0]      wb_cti_o,
    input  logic            wb_ack_i,
    input  logic [DW-1:0]   wb_dat_i
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t          state, nxt;
    logic            we_r;
    logic [AW-1:0]   addr_r;
    logic [LENW-1:0] len_r;
    logic [3:0]      sel_r;
    logic [LENW-1:0] beat_cnt;
    logic [TW-1:0]   to_cnt;

    logic cyc, stb, ack, last, timeout, accept;

    assign accept  = (state == IDLE) && cmd_valid && sdr_init_done;
    assign ack     = wb_ack_i && stb;
    assign last    = (beat_cnt == len_r);
    assign timeout = stb && !wb_ack_i && (to_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        nxt = state;
        cyc = 1'b0;
        stb = 1'b0;
        case (state)
            IDLE: begin
                if (accept)
                    nxt = cmd_we ? WR_WAIT : RD_BEAT;
            end
            WR_WAIT: begin
                cyc = 1'b1;
                if (wdat_valid)
                    nxt = WR_BEAT;
            end
            WR_BEAT: begin
                // stb follows wdat_valid so a beat is never presented without data behind it
                cyc = 1'b1;
                stb = wdat_valid;
                if (ack)
                    nxt = last ? DONE : WR_BEAT;
                else if (timeout)
                    nxt = ABORT;
                else if (!wdat_valid)
                    nxt = WR_WAIT;
            end
            RD_BEAT: begin
                cyc = 1'b1;
                stb = 1'b1;
                if (ack)
                    nxt = last ? DONE : RD_BEAT;
                else if (timeout)
                    nxt = ABORT;
            end
            DONE:    nxt = IDLE;
            ABORT:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            state      <= IDLE;
            we_r       <= 1'b0;
            addr_r     <= '0;
            len_r      <= '0;
            sel_r      <= '0;
            beat_cnt   <= '0;
            to_cnt     <= '0;
            rdat_valid <= 1'b0;
            rdat       <= '0;
        end else begin
            state      <= nxt;
            rdat_valid <= ack && !we_r;
            if (ack && !we_r)
                rdat <= wb_dat_i;
            if (accept) begin
                we_r     <= cmd_we;
                addr_r   <= cmd_addr & ~AW'(3);
                len_r    <= cmd_len;
                sel_r    <= cmd_sel;
                beat_cnt <= '0;
            end else if (ack) begin
                beat_cnt <= beat_cnt + 1'b1;
                addr_r   <= addr_r + AW'(4);
            end
            if (!stb || wb_ack_i)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

    assign cmd_ready  = (state == IDLE) && sdr_init_done;
    assign wdat_ready = ack && (state == WR_BEAT);
    assign cmd_done   = (state == DONE) || (state == ABORT);
    assign cmd_err    = (state == ABORT);

    assign wb_cyc_o  = cyc;
    assign wb_stb_o  = stb;
    assign wb_we_o   = cyc && we_r;
    assign wb_addr_o = cyc ? addr_r : '0;
    assign wb_dat_o  = (state == WR_BEAT) ? wdat : '0;
    assign wb_sel_o  = cyc ? sel_r : 4'h0;
    assign wb_cti_o  = !stb ? CTI_CLASSIC : (last ? CTI_EOB : CTI_INCR);

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench: zero-wait memory slave with ack kill switch, write-data queue and beat/done monitors.
module tb_wb_burst_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sdr_init_done = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [3:0]  cmd_sel = '0;
    logic        wdat_valid = 1'b0;
    logic        wdat_ready;
    logic [31:0] wdat = '0;
    logic        rdat_valid;
    logic [31:0] rdat;
    logic        cmd_done, cmd_err;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_addr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;

    always #5 clk = ~clk;

    wb_burst_master #(.AW(32), .DW(32), .LENW(8), .TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_resetn(rst_n), .sdr_init_done(sdr_init_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
        .rdat_valid(rdat_valid), .rdat(rdat), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
    );

    logic [31:0] mem [256];
    logic        ack_en = 1'b1;
    logic        wen = 1'b1;
    logic [31:0] wq [$];

    assign wb_ack_i = ack_en && wb_stb_o && wb_cyc_o;
    assign wb_dat_i = mem[wb_addr_o[9:2]];

    logic [31:0] b_addr [$];
    logic [31:0] b_dat [$];
    logic [2:0]  b_cti [$];
    logic [31:0] rd [$];
    int          done_cnt = 0;
    int          stb_cnt = 0;
    int          cyc_cnt = 0;
    logic        last_err = 1'b0;
    logic        done_cyc = 1'b0;

    always @(posedge clk) begin
        if (wb_stb_o && wb_ack_i && wb_we_o)
            mem[wb_addr_o[9:2]] <= wb_dat_o;
        if (wdat_valid && wdat_ready && wq.size() > 0)
            wq.delete(0);
        if (wb_stb_o && wb_ack_i) begin
            b_addr.push_back(wb_addr_o);
            b_dat.push_back(wb_dat_o);
            b_cti.push_back(wb_cti_o);
        end
        if (rdat_valid)
            rd.push_back(rdat);
        if (cmd_done) begin
            done_cnt++;
            last_err = cmd_err;
            done_cyc = wb_cyc_o;
        end
        if (wb_stb_o) stb_cnt++;
        if (wb_cyc_o) cyc_cnt++;
    end

    // Write-data source presents the queue head shortly after each falling edge
    always @(negedge clk) begin
        #2;
        wdat_valid = wen && (wq.size() > 0);
        wdat       = (wq.size() > 0) ? wq[0] : 32'h0;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        b_addr.delete();
        b_dat.delete();
        b_cti.delete();
        rd.delete();
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [7:0] len);
        bit got = 1'b0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_sel   = 4'hF;
        #1;
        for (int i = 0; i < 50 && !got; i++) begin
            if (cmd_ready) got = 1'b1;
            @(negedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!got) chk("cmd_accept", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int prev, input int budget);
        for (int i = 0; i < budget && done_cnt == prev; i++)
            @(negedge clk);
        chk("done_pulses", done_cnt - prev, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int prev;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // Reset state
        #12;
        chk("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'b0, wb_stb_o}, 32'd0);
        chk("rst_done", {31'b0, cmd_done}, 32'd0);
        chk("rst_rdat_valid", {31'b0, rdat_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Commands held off until SDRAM init completes
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 32'h100;
        cmd_len   = 8'd3;
        cmd_sel   = 4'hF;
        cyc_cnt   = 0;
        repeat (5) @(negedge clk);
        #1;
        chk("gated_ready", {31'b0, cmd_ready}, 32'd0);
        chk("gated_cyc_cycles", cyc_cnt, 32'd0);
        sdr_init_done = 1'b1;

        // Four-beat write then read back
        clear_logs();
        for (int i = 0; i < 4; i++) wq.push_back(32'hA0 + i);
        prev = done_cnt;
        send_cmd(1'b1, 32'h100, 8'd3);
        wait_done(prev, 60);
        chk("wr4_err", {31'b0, last_err}, 32'd0);
        chk("wr4_beats", b_addr.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wr4_addr%0d", i), b_addr[i], 32'h100 + 4 * i);
            chk($sformatf("wr4_dat%0d", i), b_dat[i], 32'hA0 + i);
            chk($sformatf("wr4_cti%0d", i), {29'b0, b_cti[i]}, (i == 3) ? 32'd7 : 32'd2);
        end
        clear_logs();
        prev = done_cnt;
        send_cmd(1'b0, 32'h100, 8'd3);
        wait_done(prev, 60);
        chk("rd4_count", rd.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rd4_dat%0d", i), rd[i], 32'hA0 + i);
            chk($sformatf("rd4_cti%0d", i), {29'b0, b_cti[i]}, (i == 3) ? 32'd7 : 32'd2);
        end

        // Single-beat write
        clear_logs();
        wq.push_back(32'h55);
        prev = done_cnt;
        send_cmd(1'b1, 32'h203, 8'd0);
        wait_done(prev, 40);
        chk("single_beats", b_addr.size(), 32'd1);
        chk("single_addr", b_addr[0], 32'h200);
        chk("single_cti", {29'b0, b_cti[0]}, 32'd7);
        chk("single_cyc_at_done", {31'b0, done_cyc}, 32'd0);
        chk("single_err", {31'b0, last_err}, 32'd0);

        // Eight-beat write with a 5-cycle data gap after the third beat
        clear_logs();
        for (int i = 0; i < 3; i++) wq.push_back(32'hB0 + i);
        prev = done_cnt;
        send_cmd(1'b1, 32'h300, 8'd7);
        for (int i = 0; i < 60 && b_addr.size() < 3; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        #3;
        chk("gap_stb", {31'b0, wb_stb_o}, 32'd0);
        chk("gap_cyc", {31'b0, wb_cyc_o}, 32'd1);
        for (int i = 3; i < 8; i++) wq.push_back(32'hB0 + i);
        wait_done(prev, 60);
        chk("gap_beats", b_addr.size(), 32'd8);
        chk("gap_resume_addr", b_addr[3], 32'h30C);
        chk("gap_last_addr", b_addr[7], 32'h31C);
        clear_logs();
        prev = done_cnt;
        send_cmd(1'b0, 32'h300, 8'd7);
        wait_done(prev, 60);
        for (int i = 0; i < 8; i++)
            chk($sformatf("gap_rd%0d", i), rd[i], 32'hB0 + i);

        // Slave never acks: abort after 16 strobe cycles
        clear_logs();
        ack_en  = 1'b0;
        stb_cnt = 0;
        prev = done_cnt;
        send_cmd(1'b0, 32'h0, 8'd3);
        wait_done(prev, 60);
        chk("to_stb_cycles", stb_cnt, 32'd16);
        chk("to_err", {31'b0, last_err}, 32'd1);
        chk("to_cyc_at_done", {31'b0, done_cyc}, 32'd0);
        chk("to_beats", b_addr.size(), 32'd0);

        // Address wrap at the top of the address space
        clear_logs();
        ack_en = 1'b1;
        prev = done_cnt;
        send_cmd(1'b0, 32'hFFFF_FFF8, 8'd3);
        wait_done(prev, 60);
        chk("wrap_addr0", b_addr[0], 32'hFFFF_FFF8);
        chk("wrap_addr1", b_addr[1], 32'hFFFF_FFFC);
        chk("wrap_addr2", b_addr[2], 32'h0000_0000);
        chk("wrap_addr3", b_addr[3], 32'h0000_0004);
        chk("wrap_cti3", {29'b0, b_cti[3]}, 32'd7);

        // Reset in the middle of a stalled burst
        ack_en = 1'b0;
        send_cmd(1'b0, 32'h40, 8'd3);
        repeat (3) @(negedge clk);
        prev = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("midrst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("midrst_stb", {31'b0, wb_stb_o}, 32'd0);
        chk("midrst_addr", wb_addr_o, 32'h0);
        chk("midrst_done", {31'b0, cmd_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_no_done", done_cnt - prev, 32'd0);
        chk("midrst_idle_cyc", {31'b0, wb_cyc_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
